// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: definitions shared by the pulse_gen slice.
//   state_t       - pulse-train FSM state encoding (IDLE, HIGH, LOW)
//   CNT_W_DEFAULT - default width of the width/gap/count inputs and counters
package pulse_gen_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

endpackage

// File: rtl/pulse_dcnt.sv
// pulse_dcnt: loadable down-counter with a zero flag.
//   clk      - system clock
//   reset    - synchronous active-low reset, clears the count
//   load     - load load_val (takes priority over dec)
//   load_val - value to load
//   dec      - decrement by one; holds at zero
//   value    - current count
//   zero     - high when value is zero
module pulse_dcnt
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - ONE;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: programmable pulse-train generator.
//   clk   - system clock
//   reset - synchronous active-low reset; aborts a train without done
//   trig  - start request, accepted only when idle with width/count nonzero
//   width - high cycles per pulse (latched on accepted trig)
//   gap   - low cycles between pulses (latched on accepted trig)
//   count - number of pulses (latched on accepted trig)
//   out   - registered pulse output
//   busy  - high while a train is in progress
//   done  - one-cycle completion strobe
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  input  logic [CNT_W-1:0] count,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] w_q;
  logic [CNT_W-1:0] g_q;

  logic             start;
  logic             ph_load;
  logic [CNT_W-1:0] ph_val;
  logic             ph_dec;
  logic [CNT_W-1:0] ph_value;
  logic             ph_zero;
  logic             pc_load;
  logic [CNT_W-1:0] pc_val;
  logic             pc_dec;
  logic [CNT_W-1:0] pc_value;
  logic             pc_zero;

  assign start = trig && (width != '0) && (count != '0);

  // Phase counter: cycles remaining in the current high or low phase.
  pulse_dcnt #(.CNT_W(CNT_W)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (ph_dec),
    .value    (ph_value),
    .zero     (ph_zero)
  );

  // Pulse counter: pulses remaining after the current one.
  pulse_dcnt #(.CNT_W(CNT_W)) u_pulses (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .load_val (pc_val),
    .dec      (pc_dec),
    .value    (pc_value),
    .zero     (pc_zero)
  );

  // Counter controls are derived from the same state/zero terms the FSM uses,
  // so each counter reload lines up with the matching state transition.
  always_comb begin
    ph_load = 1'b0;
    ph_val  = '0;
    ph_dec  = 1'b0;
    pc_load = 1'b0;
    pc_val  = '0;
    pc_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          ph_load = 1'b1;
          ph_val  = width - ONE;
          pc_load = 1'b1;
          pc_val  = count - ONE;
        end
      end
      HIGH: begin
        if (ph_zero) begin
          if (!pc_zero) begin
            pc_dec  = 1'b1;
            ph_load = 1'b1;
            ph_val  = (g_q == '0) ? (w_q - ONE) : (g_q - ONE);
          end
        end else begin
          ph_dec = 1'b1;
        end
      end
      LOW: begin
        if (ph_zero) begin
          ph_load = 1'b1;
          ph_val  = w_q - ONE;
        end else begin
          ph_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      out   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      w_q   <= '0;
      g_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            w_q   <= width;
            g_q   <= gap;
            state <= HIGH;
            out   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        HIGH: begin
          if (ph_zero) begin
            if (pc_zero) begin
              state <= IDLE;
              out   <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (g_q != '0) begin
              state <= LOW;
              out   <= 1'b0;
            end
          end
        end
        LOW: begin
          if (ph_zero) begin
            state <= HIGH;
            out   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          out   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: directed self-checking bench for pulse_gen.
// Cycle k below means the values seen just after the k-th rising edge
// following the edge that sampled trig (so out is expected high at k=1).
module tb_pulse_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       trig;
  logic [7:0] width;
  logic [7:0] gap;
  logic [7:0] count;
  logic       out;
  logic       busy;
  logic       done;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pulse_gen #(.CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .trig  (trig),
    .width (width),
    .gap   (gap),
    .count (count),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    trig  = 1'b0;
    width = 8'd3;
    gap   = 8'd1;
    count = 8'd2;
    for (int i = 0; i < 3; i++) begin
      trig = ~trig;
      tick();
      vec++;
      if ({out, busy, done} !== 3'b000) begin
        errs++;
        $display("FAIL reset_hold[%0d]: out/busy/done=%b expected 000", i, {out, busy, done});
      end
    end
    trig  = 1'b0;
    reset = 1'b1;
    tick();
    vec++;
    if ({out, busy, done} !== 3'b000) begin
      errs++;
      $display("FAIL reset_release: out/busy/done=%b expected 000", {out, busy, done});
    end
  endtask

  task automatic test_gap();
    // w=3 g=2 c=2: out high k1..3 and k6..8, busy k1..8, done k9
    logic [9:0] eo = 10'b0011100111;
    logic [9:0] eb = 10'b0011111111;
    logic [9:0] ed = 10'b0100000000;
    width = 8'd3; gap = 8'd2; count = 8'd2; trig = 1'b1;
    tick();
    trig = 1'b0;
    width = 8'd7; gap = 8'd0; count = 8'd9;   // must not disturb the train
    for (int k = 1; k <= 10; k++) begin
      vec++;
      if ({out, busy, done} !== {eo[k-1], eb[k-1], ed[k-1]}) begin
        errs++;
        $display("FAIL gap_train k=%0d: out/busy/done=%b expected %b",
                 k, {out, busy, done}, {eo[k-1], eb[k-1], ed[k-1]});
      end
      if (k < 10) tick();
    end
  endtask

  task automatic test_no_gap();
    // w=2 g=0 c=3: out continuously high k1..6, done k7
    logic [7:0] eo = 8'b00111111;
    logic [7:0] eb = 8'b00111111;
    logic [7:0] ed = 8'b01000000;
    width = 8'd2; gap = 8'd0; count = 8'd3; trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      vec++;
      if ({out, busy, done} !== {eo[k-1], eb[k-1], ed[k-1]}) begin
        errs++;
        $display("FAIL no_gap k=%0d: out/busy/done=%b expected %b",
                 k, {out, busy, done}, {eo[k-1], eb[k-1], ed[k-1]});
      end
      if (k < 8) tick();
    end
  endtask

  task automatic test_ignored();
    logic [6:0] eo = 7'b0001111;
    logic [6:0] eb = 7'b0001111;
    logic [6:0] ed = 7'b0010000;
    // zero width, then zero count: nothing happens
    for (int t = 0; t < 2; t++) begin
      width = (t == 0) ? 8'd0 : 8'd3;
      count = (t == 0) ? 8'd5 : 8'd0;
      gap   = 8'd1;
      trig  = 1'b1;
      tick();
      trig = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        vec++;
        if ({out, busy, done} !== 3'b000) begin
          errs++;
          $display("FAIL ignored_zero t=%0d k=%0d: out/busy/done=%b expected 000",
                   t, k, {out, busy, done});
        end
        tick();
      end
    end
    // w=4 c=1 with a retrigger at T+2: done stays at k5
    width = 8'd4; gap = 8'd1; count = 8'd1; trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      vec++;
      if ({out, busy, done} !== {eo[k-1], eb[k-1], ed[k-1]}) begin
        errs++;
        $display("FAIL busy_retrig k=%0d: out/busy/done=%b expected %b",
                 k, {out, busy, done}, {eo[k-1], eb[k-1], ed[k-1]});
      end
      if (k == 2) begin
        trig  = 1'b1;
        width = 8'd9;
        count = 8'd3;
      end
      if (k == 3) trig = 1'b0;
      if (k < 7) tick();
    end
  endtask

  task automatic test_abort();
    width = 8'd5; gap = 8'd0; count = 8'd1; trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      vec++;
      if ({out, busy, done} !== 3'b110) begin
        errs++;
        $display("FAIL abort_pre k=%0d: out/busy/done=%b expected 110", k, {out, busy, done});
      end
      if (k == 2) reset = 1'b0;
      tick();
    end
    reset = 1'b1;
    for (int k = 3; k <= 8; k++) begin
      vec++;
      if ({out, busy, done} !== 3'b000) begin
        errs++;
        $display("FAIL abort_post k=%0d: out/busy/done=%b expected 000", k, {out, busy, done});
      end
      tick();
    end
    // clean train afterwards: w=2 c=1
    width = 8'd2; count = 8'd1; trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      vec++;
      if ({out, busy, done} !== ((k == 3) ? 3'b001 : 3'b110)) begin
        errs++;
        $display("FAIL abort_restart k=%0d: out/busy/done=%b expected %b",
                 k, {out, busy, done}, ((k == 3) ? 3'b001 : 3'b110));
      end
      if (k < 3) tick();
    end
  endtask

  task automatic test_back_to_back();
    // w=1 c=1, retrigger in the done cycle (k=2)
    logic [4:0] eo = 5'b00101;
    logic [4:0] eb = 5'b00101;
    logic [4:0] ed = 5'b01010;
    width = 8'd1; gap = 8'd0; count = 8'd1; trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      vec++;
      if ({out, busy, done} !== {eo[k-1], eb[k-1], ed[k-1]}) begin
        errs++;
        $display("FAIL back_to_back k=%0d: out/busy/done=%b expected %b",
                 k, {out, busy, done}, {eo[k-1], eb[k-1], ed[k-1]});
      end
      trig = (k == 2);
      if (k < 5) tick();
    end
    trig = 1'b0;
  endtask

  task automatic test_max();
    // w=g=c=255: spot-check first pulse edge and first gap cycle
    width = 8'd255; gap = 8'd255; count = 8'd255; trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      if (k == 255 || k == 256) begin
        vec++;
        if ({out, busy, done} !== ((k == 255) ? 3'b110 : 3'b010)) begin
          errs++;
          $display("FAIL max_train k=%0d: out/busy/done=%b expected %b",
                   k, {out, busy, done}, ((k == 255) ? 3'b110 : 3'b010));
        end
      end
      if (k < 256) tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_gap();
    test_no_gap();
    test_ignored();
    test_abort();
    test_back_to_back();
    test_max();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
